// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer running on the reference clock.
// Pulses the PLL reset, qualifies the synchronised lock for a stable window,
// retries on timeout, and raises sticky lock-lost / failure flags.
module pll_lock_sequencer #(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned CNT_W               = 16
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       soft_reset,
  output logic       pll_rst,
  output logic       clk_ready,
  output logic       lock_lost,
  output logic       fail,
  output logic [1:0] retry_count,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    StResetPll  = 3'd0,
    StWaitLock  = 3'd1,
    StStabilize = 3'd2,
    StReady     = 3'd3,
    StFail      = 3'd4
  } state_e;

  // Terminal counts, expressed in counter width
  localparam logic [CNT_W-1:0] RstLast     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] StableLast  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [1:0]       MaxRetry    = 2'(MAX_RETRIES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sync_q;
  logic [1:0]       retry_q, retry_d;
  logic             lock_lost_q, lock_lost_d;
  logic             fail_q, fail_d;
  logic             locked_s;

  assign locked_s = sync_q[1];

  // Two-flop synchroniser for the asynchronous PLL lock output
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pll_locked};
    end
  end

  // Next-state, shared counter, retry and sticky-flag logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    retry_d     = retry_q;
    lock_lost_d = lock_lost_q;
    fail_d      = fail_q;

    case (state_q)
      StResetPll: begin
        if (cnt_q == RstLast) state_d = StWaitLock;
      end
      StWaitLock: begin
        // Lock wins over a coincident timeout
        if (locked_s) begin
          state_d = StStabilize;
        end else if (cnt_q == TimeoutLast) begin
          if (retry_q == MaxRetry) begin
            state_d = StFail;
            fail_d  = 1'b1;
          end else begin
            state_d = StResetPll;
            retry_d = retry_q + 1'b1;
          end
        end
      end
      StStabilize: begin
        if (!locked_s) begin
          state_d = StWaitLock;
        end else if (cnt_q == StableLast) begin
          state_d = StReady;
        end
      end
      StReady: begin
        cnt_d = cnt_q;
        if (!locked_s) begin
          state_d     = StResetPll;
          lock_lost_d = 1'b1;
          retry_d     = 2'd0;
        end
      end
      StFail: begin
        cnt_d = cnt_q;
      end
      default: begin
        state_d = StResetPll;
      end
    endcase

    // Restart request overrides everything, including a same-cycle lock drop
    if (soft_reset) begin
      state_d     = StResetPll;
      retry_d     = 2'd0;
      lock_lost_d = 1'b0;
      fail_d      = 1'b0;
    end

    // Counter restarts on every state change and while soft_reset is held
    if (soft_reset || (state_d != state_q)) cnt_d = '0;
  end

  // State, counter and flag registers
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q     <= StResetPll;
      cnt_q       <= '0;
      retry_q     <= 2'd0;
      lock_lost_q <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      lock_lost_q <= lock_lost_d;
      fail_q      <= fail_d;
    end
  end

  // Moore outputs decoded from the state register
  always_comb begin
    pll_rst     = (state_q == StResetPll) || (state_q == StFail);
    clk_ready   = (state_q == StReady);
    state_dbg   = state_q;
    retry_count = retry_q;
    lock_lost   = lock_lost_q;
    fail        = fail_q;
  end

endmodule
